glyph_pixel_streamer: RTL
=========================

Name: glyph_pixel_streamer

Overview:
- Holds a short text string and serializes it into a row-major 1-bit pixel stream for the display path.
- Upstream of AlphanumeralBitMap: drives its character input and consumes its registered 6x6 bitmap output, which arrives one cycle after the request.
- Downstream, the pixel stream is consumed through a valid/ready handshake.

Parameters:
NUM_CHARS, 8, number of character slots in the string buffer (>=1)
GAP, 1, blank pixel columns inserted between adjacent characters (>=0, not after last char)
IW, $clog2(NUM_CHARS) (min 1), slot index width (derived, localparam)

Ports:
clk  in  1  system clock, all logic on posedge
rst_l  in  1  synchronous active-low reset
wr_en  in  1  write one buffer slot this cycle
wr_addr  in  IW  slot index to write
wr_char  in  8  ASCII value to write
start  in  1  begin streaming the buffer contents
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse when the last pixel is accepted
char_out  out  8  character to AlphanumeralBitMap (its character input)
bitmap_in  in  6x6 ([0:5] x 6)  bitmap from AlphanumeralBitMap, valid 1 cycle after char_out
pix_valid  out  1  pix_data/pix_row/pix_col valid
pix_ready  in  1  consumer accepts the pixel
pix_data  out  1  pixel value (1 = lit)
pix_row  out  3  glyph row 0..5 of current pixel
pix_col  out  16  column within the line, 0..W-1

Behaviour:
- W = NUM_CHARS*6 + (NUM_CHARS-1)*GAP. One pass emits 6*W pixels: row 0 left to right, then row 1, through row 5.
- Buffer: NUM_CHARS x 8 regs, reset to 8'h20 (maps to a blank glyph).
  - wr_en writes only in IDLE; ignored while busy.
  - wr_addr >= NUM_CHARS is ignored.
- FSM states: IDLE, FETCH, LOAD, EMIT, GAP, FIN.
  - IDLE: start=1 clears row_idx, char_idx, bit_idx and pix_col to 0, then goes to FETCH. start in any other state is ignored.
  - FETCH (1 cycle): char_out = buf[char_idx]. Goes to LOAD.
  - LOAD (1 cycle): char_out held. Captures row_bits <= bitmap_in[row_idx]. Goes to EMIT.
  - EMIT: pix_valid=1, pix_data=row_bits[bit_idx], where index 0 is leftmost (MSB of the 6-bit glyph value).
    - Each handshake (pix_valid&pix_ready) increments bit_idx and pix_col.
    - After bit 5 is accepted: go to GAP if GAP>0 and char_idx<NUM_CHARS-1; else advance.
  - GAP: pix_valid=1, pix_data=0 for GAP accepted pixels, then advance.
  - advance:
    - If char_idx<NUM_CHARS-1: char_idx++, go to FETCH.
    - Else if row_idx<5: row_idx++, char_idx=0, pix_col=0, go to FETCH.
    - Else go to FIN.
  - FIN (1 cycle): done=1, busy=0 from the next cycle, go to IDLE.
- Timing: start sampled at edge t gives FETCH in cycle t+1, LOAD t+2, first pix_valid t+3. There are 2 bubble cycles (pix_valid=0) before every character's first pixel.
- busy=1 in FETCH, LOAD, EMIT and GAP; busy=0 in IDLE and FIN.
- char_out is driven as buf[char_idx] in all states, so it is stable through FETCH and LOAD.
- Backpressure: while pix_valid&!pix_ready, pix_data, pix_row and pix_col hold and no state advances. pix_valid never drops until its pixel is accepted.
- Reset (rst_l=0 at a posedge), including mid-stream:
  - state IDLE.
  - busy, done and pix_valid = 0; pix_data = 0.
  - pix_row, pix_col and char_idx = 0.
  - Buffer refilled with 8'h20.
  - No done pulse for the aborted pass.
- Unsupported ASCII values produce all-zero glyph rows (the bitmap returns 0); no special handling here.
- pix_row = row_idx. pix_col width 16 supports W up to 65535.

Test Plan:
- NUM_CHARS=2, GAP=1, write "A","B", start, pix_ready=1 -> first pix_valid 3 cycles after start. Row 0 stream 0111100111110, 13 px with pix_col 0..12. 78 px total. done pulses once, 1 cycle after the 78th accept, then busy=0.
- Same load with pix_ready toggling 1/0 each cycle -> identical pixel sequence; outputs stable during stalls. done only after 78 accepts.
- Write "#" (unsupported) and "1", GAP=0 -> first 6 px of each row are 0. Row 0 = 000000000100 (6'h04).
- start and wr_en asserted while busy -> no restart and buffer unchanged. Second pass after done reproduces the first pass exactly.
- rst_l=0 mid-row 3 -> next cycle pix_valid=0, busy=0, buffer all 8'h20, no done pulse. A new start streams all-zero pixels.
- NUM_CHARS=1, "." -> 36 px with no gaps. Rows 4 and 5 = 001100 (6'h0c), other rows 0.

Source files
------------

// File: rtl/glyph_pixel_streamer.sv
// Serializes a small character buffer into a row-major 1-bit pixel stream,
// fetching each glyph row from an external bitmap ROM that answers one cycle late.
module glyph_pixel_streamer #(
  parameter int NUM_CHARS = 8,
  parameter int GAP       = 1,
  localparam int IW       = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_addr,
  input  logic [7:0]      wr_char,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [7:0]      char_out,
  input  logic [0:5][5:0] bitmap_in,
  output logic            pix_valid,
  input  logic            pix_ready,
  output logic            pix_data,
  output logic [2:0]      pix_row,
  output logic [15:0]     pix_col
);

  localparam logic [IW-1:0] LAST_CHAR = IW'(NUM_CHARS - 1);
  localparam logic [15:0]   GAP_LAST  = (GAP > 0) ? 16'(GAP - 1) : 16'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_EMIT,
    ST_GAP,
    ST_FIN
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      char_buf_q [NUM_CHARS];
  logic [IW-1:0]   char_idx_q, char_idx_d;
  logic [2:0]      row_idx_q, row_idx_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [15:0]     gap_cnt_q, gap_cnt_d;
  logic [15:0]     pix_col_q, pix_col_d;
  logic [5:0]      row_bits_q, row_bits_d;
  logic            advance;

  // Writes land only while idle; out-of-range addresses match no slot.
  generate
    for (genvar gi = 0; gi < NUM_CHARS; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (!rst_l) begin
          char_buf_q[gi] <= 8'h20;
        end else if (wr_en && (state_q == ST_IDLE) && (wr_addr == IW'(gi))) begin
          char_buf_q[gi] <= wr_char;
        end
      end
    end
  endgenerate

  always_comb begin
    char_out = char_buf_q[0];
    for (int i = 1; i < NUM_CHARS; i++) begin
      if (char_idx_q == IW'(i)) char_out = char_buf_q[i];
    end
  end

  assign busy      = (state_q == ST_FETCH) || (state_q == ST_LOAD) ||
                     (state_q == ST_EMIT)  || (state_q == ST_GAP);
  assign done      = (state_q == ST_FIN);
  assign pix_valid = (state_q == ST_EMIT) || (state_q == ST_GAP);
  // Bit index 0 is the leftmost pixel, i.e. the MSB of the glyph row.
  assign pix_data  = (state_q == ST_EMIT) ? row_bits_q[3'd5 - bit_idx_q] : 1'b0;
  assign pix_row   = row_idx_q;
  assign pix_col   = pix_col_q;

  always_comb begin
    state_d    = state_q;
    char_idx_d = char_idx_q;
    row_idx_d  = row_idx_q;
    bit_idx_d  = bit_idx_q;
    gap_cnt_d  = gap_cnt_q;
    pix_col_d  = pix_col_q;
    row_bits_d = row_bits_q;
    advance    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          row_idx_d  = 3'd0;
          char_idx_d = '0;
          bit_idx_d  = 3'd0;
          pix_col_d  = 16'd0;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        row_bits_d = bitmap_in[row_idx_q];
        bit_idx_d  = 3'd0;
        state_d    = ST_EMIT;
      end
      ST_EMIT: begin
        if (pix_ready) begin
          pix_col_d = pix_col_q + 16'd1;
          if (bit_idx_q == 3'd5) begin
            bit_idx_d = 3'd0;
            if ((GAP > 0) && (char_idx_q != LAST_CHAR)) begin
              gap_cnt_d = 16'd0;
              state_d   = ST_GAP;
            end else begin
              advance = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_GAP: begin
        if (pix_ready) begin
          pix_col_d = pix_col_q + 16'd1;
          if (gap_cnt_q == GAP_LAST) advance = 1'b1;
          else                       gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Next character on this row, else wrap to the next row, else finish.
    if (advance) begin
      if (char_idx_q != LAST_CHAR) begin
        char_idx_d = char_idx_q + IW'(1);
        state_d    = ST_FETCH;
      end else if (row_idx_q != 3'd5) begin
        row_idx_d  = row_idx_q + 3'd1;
        char_idx_d = '0;
        pix_col_d  = 16'd0;
        state_d    = ST_FETCH;
      end else begin
        state_d = ST_FIN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q    <= ST_IDLE;
      char_idx_q <= '0;
      row_idx_q  <= 3'd0;
      bit_idx_q  <= 3'd0;
      gap_cnt_q  <= 16'd0;
      pix_col_q  <= 16'd0;
      row_bits_q <= 6'd0;
    end else begin
      state_q    <= state_d;
      char_idx_q <= char_idx_d;
      row_idx_q  <= row_idx_d;
      bit_idx_q  <= bit_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      pix_col_q  <= pix_col_d;
      row_bits_q <= row_bits_d;
    end
  end

endmodule
